// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// access-size encoding and a legality helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_DONE  = 3'd5
    } lsu_state_e;

    // funct3[1:0] selects the access size
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    // Loads allow B/H/W/BU/HU, stores allow B/H/W only.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (is_load) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte-enable mask over two beats, store-data
// shift into lanes, and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [63:0] rbuf,
    output logic [7:0]  mask,
    output logic [63:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [3:0]  base;
    logic [5:0]  bit_off;
    logic [31:0] shifted;

    // Mask, store shift and load extraction all derive from size and offset
    always_comb begin
        base      = 4'b1111;
        bit_off   = {1'b0, off, 3'b000};
        shifted   = rbuf[bit_off +: 32];
        rdata_ext = shifted;
        case (funct3[1:0])
            SZ_BYTE: base = 4'b0001;
            SZ_HALF: base = 4'b0011;
            default: base = 4'b1111;
        endcase
        mask     = {4'b0000, base} << off;
        wdata_sh = {32'h0, wdata} << bit_off;
        case (funct3)
            F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata_ext = {24'h0, shifted[7:0]};
            F3_HU:   rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation at a time, splits misaligned
// accesses into two word beats, and returns an extended load result.
//
// Memory handshake: a beat is transferred in a cycle where o_dmem_req and
// i_dmem_ready are both high; o_dmem_* hold steady while req is high and
// ready low. Read data returns on i_dmem_rvalid, never in the ready cycle,
// and is only taken in a WAIT state.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_load,
    input  logic        i_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_mask,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ready,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic [2:0]  o_state
);

    lsu_state_e  state, state_nxt;
    logic        r_load;
    logic        r_fault;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [63:0] r_buf;
    logic [31:0] r_rdata;

    logic        accept;
    logic [7:0]  mask8;
    logic [63:0] wdata_sh;
    logic [31:0] rdata_ext;
    logic [31:0] addr0;
    logic        need_beat1;

    assign accept     = i_valid && (state == ST_IDLE) && (i_load ^ i_store);
    assign addr0      = {r_addr[31:2], 2'b00};
    assign need_beat1 = (mask8[7:4] != 4'b0000);
    assign o_state    = state;

    lsu_align u_align (
        .funct3    (r_funct3),
        .off       (r_addr[1:0]),
        .wdata     (r_wdata),
        .rbuf      (r_buf),
        .mask      (mask8),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and memory-side outputs
    always_comb begin
        state_nxt    = state;
        o_dmem_req   = 1'b0;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = 32'h0;
        o_dmem_mask  = 4'h0;
        o_dmem_wdata = 32'h0;
        o_done       = 1'b0;
        o_fault      = 1'b0;
        o_rdata      = r_rdata;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (f3_legal(i_load, i_funct3)) state_nxt = ST_REQ0;
                    else                            state_nxt = ST_DONE;
                end
            end
            ST_REQ0: begin
                o_dmem_req   = 1'b1;
                o_dmem_we    = !r_load;
                o_dmem_addr  = addr0;
                o_dmem_mask  = mask8[3:0];
                o_dmem_wdata = wdata_sh[31:0];
                if (i_dmem_ready) begin
                    if (r_load)          state_nxt = ST_WAIT0;
                    else if (need_beat1) state_nxt = ST_REQ1;
                    else                 state_nxt = ST_DONE;
                end
            end
            ST_WAIT0: begin
                if (i_dmem_rvalid) begin
                    if (need_beat1) state_nxt = ST_REQ1;
                    else            state_nxt = ST_DONE;
                end
            end
            ST_REQ1: begin
                o_dmem_req   = 1'b1;
                o_dmem_we    = !r_load;
                o_dmem_addr  = addr0 + 32'd4;
                o_dmem_mask  = mask8[7:4];
                o_dmem_wdata = wdata_sh[63:32];
                if (i_dmem_ready) begin
                    if (r_load) state_nxt = ST_WAIT1;
                    else        state_nxt = ST_DONE;
                end
            end
            ST_WAIT1: begin
                if (i_dmem_rvalid) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                o_fault = r_fault;
                if (r_load && !r_fault) o_rdata = rdata_ext;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy = (state != ST_IDLE);

    // Request capture, read buffer fill and load-result hold
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_load   <= 1'b0;
            r_fault  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_buf    <= 64'h0;
            r_rdata  <= 32'h0;
        end else begin
            if (accept) begin
                r_load   <= i_load;
                r_fault  <= !f3_legal(i_load, i_funct3);
                r_funct3 <= i_funct3;
                r_addr   <= i_addr;
                r_wdata  <= i_wdata;
            end
            if (state == ST_WAIT0 && i_dmem_rvalid) r_buf[31:0]  <= i_dmem_rdata;
            if (state == ST_WAIT1 && i_dmem_rvalid) r_buf[63:32] <= i_dmem_rdata;
            if (state == ST_DONE && r_load && !r_fault) r_rdata <= rdata_ext;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one task per scenario, inline checks.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_load = 1'b0;
    logic        i_store = 1'b0;
    logic [2:0]  i_funct3 = 3'b000;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic        o_busy, o_done, o_fault;
    logic [31:0] o_rdata;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_mask;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ready = 1'b0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = 32'h0;
    logic [2:0]  o_state;

    int tests = 0;
    int fails = 0;

    load_store_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_load(i_load),
        .i_store(i_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault), .o_rdata(o_rdata),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_mask(o_dmem_mask), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ready(i_dmem_ready), .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata(i_dmem_rdata), .o_state(o_state)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Present a request for one edge; returns #1 after the acceptance edge
    task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        i_valid = 1'b1; i_load = ld; i_store = st;
        i_funct3 = f3; i_addr = a; i_wdata = wd;
        step();
        i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step();
        step();
        tests++;
        if ({o_busy, o_done, o_fault, o_dmem_req, o_dmem_we} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_ctrl got %b want 00000", {o_busy, o_done, o_fault, o_dmem_req, o_dmem_we});
        end
        tests++;
        if ({o_dmem_addr, o_dmem_mask, o_dmem_wdata, o_rdata} !== 100'h0) begin
            fails++;
            $display("FAIL reset_data got addr=%h mask=%b wdata=%h rdata=%h want zeros",
                     o_dmem_addr, o_dmem_mask, o_dmem_wdata, o_rdata);
        end
        i_rst = 1'b0;
        step();
    endtask

    task automatic test_lw();
        drive_req(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0);
        i_dmem_ready = 1'b1;
        tests++;
        if (!(o_dmem_req === 1'b1 && o_dmem_we === 1'b0 && o_dmem_addr === 32'h100 &&
              o_dmem_mask === 4'b1111 && o_busy === 1'b1 && o_done === 1'b0)) begin
            fails++;
            $display("FAIL lw_beat0 got req=%b we=%b addr=%h mask=%b busy=%b done=%b want 1 0 00000100 1111 1 0",
                     o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_mask, o_busy, o_done);
        end
        step();
        i_dmem_ready = 1'b0;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hDEAD_BEEF;
        tests++;
        if (o_done !== 1'b0 || o_dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL lw_wait got done=%b req=%b want 0 0", o_done, o_dmem_req);
        end
        step();
        i_dmem_rvalid = 1'b0;
        tests++;
        if (!(o_done === 1'b1 && o_fault === 1'b0 && o_rdata === 32'hDEAD_BEEF)) begin
            fails++;
            $display("FAIL lw_done got done=%b fault=%b rdata=%h want 1 0 deadbeef", o_done, o_fault, o_rdata);
        end
        step();
        tests++;
        if (!(o_done === 1'b0 && o_busy === 1'b0 && o_rdata === 32'hDEAD_BEEF)) begin
            fails++;
            $display("FAIL lw_hold got done=%b busy=%b rdata=%h want 0 0 deadbeef", o_done, o_busy, o_rdata);
        end
    endtask

    task automatic test_byte_loads();
        logic [2:0]  f3_v [2];
        logic [31:0] exp_v [2];
        f3_v[0] = F3_B;  exp_v[0] = 32'hFFFF_FF80;
        f3_v[1] = F3_BU; exp_v[1] = 32'h0000_0080;
        for (int k = 0; k < 2; k++) begin
            drive_req(1'b1, 1'b0, f3_v[k], 32'h0000_0103, 32'h0);
            i_dmem_ready = 1'b1;
            tests++;
            if (o_dmem_addr !== 32'h100 || o_dmem_mask !== 4'b1000) begin
                fails++;
                $display("FAIL byte_beat%0d got addr=%h mask=%b want 00000100 1000", k, o_dmem_addr, o_dmem_mask);
            end
            step();
            i_dmem_ready = 1'b0;
            i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h8000_0000;
            step();
            i_dmem_rvalid = 1'b0;
            tests++;
            if (o_done !== 1'b1 || o_rdata !== exp_v[k]) begin
                fails++;
                $display("FAIL byte_load%0d got done=%b rdata=%h want 1 %h", k, o_done, o_rdata, exp_v[k]);
            end
            step();
        end
    endtask

    task automatic test_sw_split_and_back_to_back();
        drive_req(1'b0, 1'b1, F3_W, 32'h0000_0106, 32'h1122_3344);
        i_dmem_ready = 1'b1;
        tests++;
        if (!(o_dmem_req === 1'b1 && o_dmem_we === 1'b1 && o_dmem_addr === 32'h104 &&
              o_dmem_mask === 4'b1100 && o_dmem_wdata === 32'h3344_0000)) begin
            fails++;
            $display("FAIL sw_beat0 got req=%b we=%b addr=%h mask=%b wdata=%h want 1 1 00000104 1100 33440000",
                     o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_mask, o_dmem_wdata);
        end
        step();
        tests++;
        if (!(o_dmem_req === 1'b1 && o_dmem_we === 1'b1 && o_dmem_addr === 32'h108 &&
              o_dmem_mask === 4'b0011 && o_dmem_wdata === 32'h0000_1122)) begin
            fails++;
            $display("FAIL sw_beat1 got req=%b we=%b addr=%h mask=%b wdata=%h want 1 1 00000108 0011 00001122",
                     o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_mask, o_dmem_wdata);
        end
        step();
        i_dmem_ready = 1'b0;
        tests++;
        if (!(o_done === 1'b1 && o_fault === 1'b0 && o_rdata === 32'h0000_0080)) begin
            fails++;
            $display("FAIL sw_done got done=%b fault=%b rdata=%h want 1 0 00000080", o_done, o_fault, o_rdata);
        end
        step();
        // Next request in the first idle cycle after DONE
        drive_req(1'b0, 1'b1, F3_H, 32'h0000_0102, 32'h0000_ABCD);
        tests++;
        if (!(o_busy === 1'b1 && o_dmem_req === 1'b1 && o_dmem_addr === 32'h100 &&
              o_dmem_mask === 4'b1100 && o_dmem_wdata === 32'hABCD_0000)) begin
            fails++;
            $display("FAIL sh_b2b got busy=%b req=%b addr=%h mask=%b wdata=%h want 1 1 00000100 1100 abcd0000",
                     o_busy, o_dmem_req, o_dmem_addr, o_dmem_mask, o_dmem_wdata);
        end
        i_dmem_ready = 1'b1;
        step();
        i_dmem_ready = 1'b0;
        tests++;
        if (o_done !== 1'b1 || o_dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL sh_done got done=%b req=%b want 1 0", o_done, o_dmem_req);
        end
        step();
    endtask

    task automatic test_lhu_wrap();
        drive_req(1'b1, 1'b0, F3_HU, 32'hFFFF_FFFF, 32'h0);
        i_dmem_ready = 1'b1;
        tests++;
        if (o_dmem_addr !== 32'hFFFF_FFFC || o_dmem_mask !== 4'b1000) begin
            fails++;
            $display("FAIL lhu_beat0 got addr=%h mask=%b want fffffffc 1000", o_dmem_addr, o_dmem_mask);
        end
        step();
        i_dmem_ready = 1'b0;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h3400_0000;
        step();
        i_dmem_rvalid = 1'b0;
        i_dmem_ready = 1'b1;
        tests++;
        if (o_dmem_req !== 1'b1 || o_dmem_addr !== 32'h0000_0000 || o_dmem_mask !== 4'b0001) begin
            fails++;
            $display("FAIL lhu_beat1 got req=%b addr=%h mask=%b want 1 00000000 0001", o_dmem_req, o_dmem_addr, o_dmem_mask);
        end
        step();
        i_dmem_ready = 1'b0;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h0000_0012;
        step();
        i_dmem_rvalid = 1'b0;
        tests++;
        if (o_done !== 1'b1 || o_rdata !== 32'h0000_1234) begin
            fails++;
            $display("FAIL lhu_done got done=%b rdata=%h want 1 00001234", o_done, o_rdata);
        end
        step();
    endtask

    task automatic test_stall();
        drive_req(1'b1, 1'b0, F3_H, 32'h0000_0202, 32'h0);
        i_dmem_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (!(o_busy === 1'b1 && o_dmem_req === 1'b1 && o_dmem_we === 1'b0 &&
                  o_dmem_addr === 32'h200 && o_dmem_mask === 4'b1100 && o_dmem_wdata === 32'h0)) begin
                fails++;
                $display("FAIL stall_c%0d got busy=%b req=%b we=%b addr=%h mask=%b wdata=%h want 1 1 0 00000200 1100 00000000",
                         c, o_busy, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_mask, o_dmem_wdata);
            end
            step();
        end
        i_dmem_ready = 1'b1;
        step();
        i_dmem_ready = 1'b0;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h8001_0000;
        step();
        i_dmem_rvalid = 1'b0;
        tests++;
        if (o_done !== 1'b1 || o_rdata !== 32'hFFFF_8001) begin
            fails++;
            $display("FAIL lh_stall_done got done=%b rdata=%h want 1 ffff8001", o_done, o_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive_req(1'b1, 1'b0, F3_W, 32'h0000_0300, 32'h0);
        i_dmem_ready = 1'b1;
        step();
        i_dmem_ready = 1'b0;
        i_rst = 1'b1;
        #1;
        tests++;
        if (o_dmem_req !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid got req=%b busy=%b done=%b want 0 0 0", o_dmem_req, o_busy, o_done);
        end
        step();
        i_rst = 1'b0;
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h5555_AAAA;
        step();
        i_dmem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_rdata !== 32'h0) begin
                fails++;
                $display("FAIL rst_late_rvalid%0d got done=%b busy=%b rdata=%h want 0 0 00000000", c, o_done, o_busy, o_rdata);
            end
            step();
        end
    endtask

    task automatic test_illegal();
        logic        ld_v [2];
        logic [2:0]  f3_v [2];
        ld_v[0] = 1'b1; f3_v[0] = 3'b011;
        ld_v[1] = 1'b0; f3_v[1] = 3'b100;
        for (int k = 0; k < 2; k++) begin
            drive_req(ld_v[k], !ld_v[k], f3_v[k], 32'h0000_0400, 32'hFFFF_FFFF);
            tests++;
            if (!(o_done === 1'b1 && o_fault === 1'b1 && o_dmem_req === 1'b0)) begin
                fails++;
                $display("FAIL illegal%0d got done=%b fault=%b req=%b want 1 1 0", k, o_done, o_fault, o_dmem_req);
            end
            step();
            tests++;
            if (o_done !== 1'b0 || o_fault !== 1'b0 || o_busy !== 1'b0) begin
                fails++;
                $display("FAIL illegal%0d_after got done=%b fault=%b busy=%b want 0 0 0", k, o_done, o_fault, o_busy);
            end
        end
    endtask

    task automatic test_ignored();
        drive_req(1'b1, 1'b1, F3_W, 32'h0000_0500, 32'h0);
        tests++;
        if (o_busy !== 1'b0 || o_dmem_req !== 1'b0 || o_done !== 1'b0) begin
            fails++;
            $display("FAIL both_kinds got busy=%b req=%b done=%b want 0 0 0", o_busy, o_dmem_req, o_done);
        end
        drive_req(1'b0, 1'b0, F3_W, 32'h0000_0500, 32'h0);
        tests++;
        if (o_busy !== 1'b0 || o_dmem_req !== 1'b0 || o_done !== 1'b0) begin
            fails++;
            $display("FAIL no_kind got busy=%b req=%b done=%b want 0 0 0", o_busy, o_dmem_req, o_done);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_byte_loads();
        test_sw_split_and_back_to_back();
        test_lhu_wrap();
        test_stall();
        test_illegal();
        test_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
